saturn_mouse_port: RTL and testbench

SATURN_MOUSE_PORT -- requirements
Module: saturn_mouse_port

---
 rtl/saturn_mouse_port.sv | 259 +++++++++++++++++++++++++
 tb/tb_saturn_mouse_port.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/saturn_mouse_port.sv
// saturn_mouse_port
// -----------------
// Device side of a Sega Saturn mouse port. The host selects the device by
// pulling th low. Every edge the host then makes on tr requests one nibble.
// The device answers by driving the next nibble on d and toggling tl.
//
// On selection, the mouse accumulator is captured into a local snapshot,
// and reset_acc pulses to clear the accumulator. The ten-nibble frame is:
//   0, B, F, F, flags, buttons, x[7:4], x[3:0], y[7:4], y[3:0]
// It is served from that snapshot, so motion that arrives mid-frame is
// kept for the next read.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   flags      {y_ov, x_ov, y_sign, x_sign} from the accumulator
//   buttons    {start/middle-ext, middle, right, left} from the accumulator
//   x, y       accumulated deltas, low 8 bits
//   th         host select, asynchronous, low = selected
//   tr         host request, asynchronous, each edge requests one nibble
//   tl         acknowledge, toggles once per delivered nibble
//   d          data nibble to the host
//   reset_acc  one-cycle pulse clearing the accumulator after the snapshot
//   busy       high whenever a transfer is in progress
//
// Parameters
//   SETUP_CYCLES    clk cycles between driving a nibble and toggling tl
//   TIMEOUT_CYCLES  idle clk cycles allowed between tr edges before the
//                   transfer is abandoned
module saturn_mouse_port #(
  parameter int SETUP_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] flags,
  input  logic [3:0] buttons,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       th,
  input  logic       tr,
  output logic       tl,
  output logic [3:0] d,
  output logic       reset_acc,
  output logic       busy
);

  // Counter widths only need to hold the terminal count (N-1).
  localparam int SetupW   = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam int TimeoutW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [SetupW-1:0]   SetupLast   = SetupW'(SETUP_CYCLES - 1);
  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] LastIdx = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    WAIT_TR,
    SETUP,
    DONE
  } state_e;

  // Synchronizer and edge-detect registers for the two host lines.
  logic th_meta_q, th_sync_q, th_prev_q;
  logic tr_meta_q, tr_sync_q, tr_prev_q;

  // Start-up qualification of th (see the arming logic below).
  logic [1:0] flush_q, flush_d;
  logic       armed_q, armed_d;

  // Transfer state.
  state_e                state_q, state_d;
  logic [23:0]           snap_q, snap_d;
  logic [3:0]            idx_q, idx_d;
  logic [SetupW-1:0]     setup_cnt_q, setup_cnt_d;
  logic [TimeoutW-1:0]   timeout_q, timeout_d;
  logic [3:0]            d_q, d_d;
  logic                  tl_q, tl_d;

  logic       th_fall;
  logic       tr_edge;
  logic [3:0] nibble;

  // Two-flop synchronizers plus a delayed copy for edge detection. They
  // reset high, which is the idle level of the host lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      th_meta_q <= 1'b1;
      th_sync_q <= 1'b1;
      th_prev_q <= 1'b1;
      tr_meta_q <= 1'b1;
      tr_sync_q <= 1'b1;
      tr_prev_q <= 1'b1;
    end else begin
      th_meta_q <= th;
      th_sync_q <= th_meta_q;
      th_prev_q <= th_sync_q;
      tr_meta_q <= tr;
      tr_sync_q <= tr_meta_q;
      tr_prev_q <= tr_sync_q;
    end
  end

  // The synchronizers reset to 1. If th is already low when reset is
  // released, the synchronized value falls, and that looks like a
  // selection. A selection is only accepted after th has been seen high
  // once the synchronizer holds real input. So a reset in the middle of a
  // transfer needs a fresh deselect/select from the host.
  always_comb begin
    flush_d = flush_q;
    armed_d = armed_q;
    if (flush_q != 2'd2) begin
      flush_d = flush_q + 2'd1;
    end else if (th_sync_q) begin
      armed_d = 1'b1;
    end
  end

  assign th_fall = armed_q & th_prev_q & ~th_sync_q;
  assign tr_edge = tr_sync_q ^ tr_prev_q;

  // Frame layout. The snapshot is packed as {flags, buttons, x, y}.
  always_comb begin
    nibble = 4'hF;
    case (idx_q)
      4'd0:    nibble = 4'h0;
      4'd1:    nibble = 4'hB;
      4'd2:    nibble = 4'hF;
      4'd3:    nibble = 4'hF;
      4'd4:    nibble = snap_q[23:20];
      4'd5:    nibble = snap_q[19:16];
      4'd6:    nibble = snap_q[15:12];
      4'd7:    nibble = snap_q[11:8];
      4'd8:    nibble = snap_q[7:4];
      4'd9:    nibble = snap_q[3:0];
      default: nibble = 4'hF;
    endcase
  end

  // Next-state logic for the transfer FSM. A deselect (synchronized th
  // high) overrides everything else, so it is applied after the case.
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    idx_d       = idx_q;
    setup_cnt_d = setup_cnt_q;
    timeout_d   = timeout_q;
    d_d         = d_q;
    tl_d        = tl_q;

    case (state_q)
      IDLE: begin
        d_d   = 4'hF;
        tl_d  = 1'b1;
        idx_d = 4'd0;
        // tr edges are ignored here, so a tr edge that coincides with
        // the selection is dropped.
        if (th_fall) begin
          state_d = SNAP;
        end
      end

      SNAP: begin
        snap_d    = {flags, buttons, x, y};
        idx_d     = 4'd0;
        timeout_d = '0;
        state_d   = WAIT_TR;
      end

      WAIT_TR: begin
        if (tr_edge) begin
          d_d         = nibble;
          setup_cnt_d = '0;
          timeout_d   = '0;
          state_d     = SETUP;
        end else if (timeout_q == TimeoutLast) begin
          // The host went quiet while still selecting us. Give up on
          // this frame and wait for a fresh selection.
          state_d   = IDLE;
          d_d       = 4'hF;
          tl_d      = 1'b1;
          idx_d     = 4'd0;
          timeout_d = '0;
        end else begin
          timeout_d = timeout_q + TimeoutW'(1);
        end
      end

      SETUP: begin
        // tr edges seen here are deliberately not remembered.
        if (setup_cnt_q == SetupLast) begin
          tl_d = ~tl_q;
          if (idx_q == LastIdx) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = WAIT_TR;
          end
        end else begin
          setup_cnt_d = setup_cnt_q + SetupW'(1);
        end
      end

      DONE: begin
        state_d = DONE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Deselect abandons any partial transfer. The snapshot is simply
    // dropped; the accumulator has already been cleared.
    if (state_q != IDLE && th_sync_q) begin
      state_d     = IDLE;
      d_d         = 4'hF;
      tl_d        = 1'b1;
      idx_d       = 4'd0;
      setup_cnt_d = '0;
      timeout_d   = '0;
    end
  end

  // State registers for the FSM and its datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_q     <= 2'd0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      snap_q      <= '0;
      idx_q       <= 4'd0;
      setup_cnt_q <= '0;
      timeout_q   <= '0;
      d_q         <= 4'hF;
      tl_q        <= 1'b1;
    end else begin
      flush_q     <= flush_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      snap_q      <= snap_d;
      idx_q       <= idx_d;
      setup_cnt_q <= setup_cnt_d;
      timeout_q   <= timeout_d;
      d_q         <= d_d;
      tl_q        <= tl_d;
    end
  end

  // SNAP lasts exactly one cycle, so decoding it gives a single pulse per
  // transfer.
  assign reset_acc = (state_q == SNAP);
  assign busy      = (state_q != IDLE);
  assign d         = d_q;
  assign tl        = tl_q;

endmodule

// File: tb/tb_saturn_mouse_port.sv
// tb_saturn_mouse_port
// --------------------
// Randomized and directed checks of saturn_mouse_port.
// The expected frame is built from the input values with plain arithmetic.
// A monitor watches tl and reset_acc to count acknowledges and
// accumulator clears.
module tb_saturn_mouse_port;

  localparam int Setup   = 4;
  localparam int Timeout = 100;

  typedef logic [3:0] nib_t [10];

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] flags = 4'h0;
  logic [3:0] buttons = 4'h0;
  logic [7:0] x = 8'h00;
  logic [7:0] y = 8'h00;
  logic       th = 1'b1;
  logic       tr = 1'b0;
  logic       tl;
  logic [3:0] d;
  logic       reset_acc;
  logic       busy;

  int passed = 0;
  int total  = 0;

  saturn_mouse_port #(
    .SETUP_CYCLES  (Setup),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .flags    (flags),
    .buttons  (buttons),
    .x        (x),
    .y        (y),
    .th       (th),
    .tr       (tr),
    .tl       (tl),
    .d        (d),
    .reset_acc(reset_acc),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Monitor, sampling away from the active edge. Each tl change is one
  // delivered nibble; d is captured at that moment.
  int         tlToggles = 0;
  int         accPulses = 0;
  logic       prevTl = 1'b1;
  logic [3:0] lastNib = 4'h0;

  always @(negedge clk) begin
    if (tl !== prevTl) begin
      tlToggles <= tlToggles + 1;
      lastNib   <= d;
    end
    prevTl <= tl;
    if (reset_acc === 1'b1) accPulses <= accPulses + 1;
  end

  // Reference frame, computed directly from the input values.
  function automatic nib_t model_frame(logic [3:0] f, logic [3:0] b,
                                       logic [7:0] xv, logic [7:0] yv);
    nib_t m;
    m[0] = 4'h0;
    m[1] = 4'hB;
    m[2] = 4'hF;
    m[3] = 4'hF;
    m[4] = f;
    m[5] = b;
    m[6] = 4'(xv / 16);
    m[7] = 4'(xv % 16);
    m[8] = 4'(yv / 16);
    m[9] = 4'(yv % 16);
    return m;
  endfunction

  // Stimulus helpers: select, deselect and one tr edge with a 20-cycle slot.
  task automatic select_dev();
    @(negedge clk);
    th = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic deselect_dev();
    @(negedge clk);
    th = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_nibble(output logic [3:0] got, output int toggles);
    int start;
    start = tlToggles;
    tr = ~tr;
    repeat (20) @(negedge clk);
    toggles = tlToggles - start;
    got = lastNib;
  endtask

  // Outputs while reset is held low.
  task automatic test_reset();
    reset_n = 1'b0;
    th = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (tl !== 1'b1) $display("[TB] FAIL reset_tl got %b want 1", tl); else passed++;
    total++; if (d !== 4'hF) $display("[TB] FAIL reset_d got %h want F", d); else passed++;
    total++; if (reset_acc !== 1'b0) $display("[TB] FAIL reset_acc got %b want 0", reset_acc); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else passed++;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // The fixed frame: flags 3, buttons 5, x A7, y 1C.
  task automatic test_full_read();
    nib_t       exp;
    logic [3:0] got;
    int         tg, tlStart, accStart;
    flags = 4'h3; buttons = 4'h5; x = 8'hA7; y = 8'h1C;
    exp = model_frame(flags, buttons, x, y);
    tlStart = tlToggles;
    accStart = accPulses;
    select_dev();
    for (int i = 0; i < 10; i++) begin
      send_nibble(got, tg);
      total++; if (got !== exp[i]) $display("[TB] FAIL full_nib%0d got %h want %h", i, got, exp[i]); else passed++;
    end
    total++; if (tlToggles - tlStart != 10) $display("[TB] FAIL full_tl_count got %0d want 10", tlToggles - tlStart); else passed++;
    total++; if (accPulses - accStart != 1) $display("[TB] FAIL full_acc_pulses got %0d want 1", accPulses - accStart); else passed++;
    total++; if (busy !== 1'b1) $display("[TB] FAIL done_busy got %b want 1", busy); else passed++;
    total++; if (d !== 4'hC) $display("[TB] FAIL done_d got %h want C", d); else passed++;
    send_nibble(got, tg);
    total++; if (tg != 0) $display("[TB] FAIL done_extra_tr toggles got %0d want 0", tg); else passed++;
    deselect_dev();
    total++; if (busy !== 1'b0) $display("[TB] FAIL desel_busy got %b want 0", busy); else passed++;
    total++; if (d !== 4'hF) $display("[TB] FAIL desel_d got %h want F", d); else passed++;
    total++; if (tl !== 1'b1) $display("[TB] FAIL desel_tl got %b want 1", tl); else passed++;
  endtask

  // Random accumulator contents over several frames.
  task automatic test_random();
    nib_t       exp;
    logic [3:0] got;
    int         tg, accStart;
    for (int n = 0; n < 4; n++) begin
      flags   = 4'($urandom_range(0, 15));
      buttons = 4'($urandom_range(0, 15));
      x       = 8'($urandom_range(0, 255));
      y       = 8'($urandom_range(0, 255));
      exp = model_frame(flags, buttons, x, y);
      accStart = accPulses;
      select_dev();
      for (int i = 0; i < 10; i++) begin
        send_nibble(got, tg);
        total++;
        if (got !== exp[i] || tg != 1)
          $display("[TB] FAIL rand%0d_nib%0d got %h/%0d want %h/1", n, i, got, tg, exp[i]);
        else passed++;
      end
      total++; if (accPulses - accStart != 1) $display("[TB] FAIL rand%0d_acc got %0d want 1", n, accPulses - accStart); else passed++;
      deselect_dev();
    end
  endtask

  // Accumulator changes after the snapshot must not reach the host.
  task automatic test_snapshot();
    nib_t       exp;
    logic [3:0] got;
    int         tg;
    flags = 4'h3; buttons = 4'h5; x = 8'hA7; y = 8'h1C;
    exp = model_frame(flags, buttons, x, y);
    select_dev();
    x = 8'h55; y = 8'h99; flags = 4'hE; buttons = 4'h2;
    for (int i = 0; i < 10; i++) begin
      send_nibble(got, tg);
      total++; if (got !== exp[i]) $display("[TB] FAIL snap_nib%0d got %h want %h", i, got, exp[i]); else passed++;
    end
    deselect_dev();
  endtask

  // Deselect after five nibbles, then a clean restart.
  task automatic test_abort();
    logic [3:0] got;
    int         tg, accStart;
    flags = 4'h3; buttons = 4'h5; x = 8'hA7; y = 8'h1C;
    select_dev();
    for (int i = 0; i < 5; i++) send_nibble(got, tg);
    th = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy got %b want 0", busy); else passed++;
    total++; if (d !== 4'hF) $display("[TB] FAIL abort_d got %h want F", d); else passed++;
    total++; if (tl !== 1'b1) $display("[TB] FAIL abort_tl got %b want 1", tl); else passed++;
    repeat (4) @(negedge clk);
    accStart = accPulses;
    select_dev();
    send_nibble(got, tg);
    total++; if (got !== 4'h0 || tg != 1) $display("[TB] FAIL restart_nib0 got %h/%0d want 0/1", got, tg); else passed++;
    total++; if (accPulses - accStart != 1) $display("[TB] FAIL restart_acc got %0d want 1", accPulses - accStart); else passed++;
    deselect_dev();
  endtask

  // The host keeps th low but stops toggling tr.
  task automatic test_timeout();
    logic [3:0] got;
    int         tg;
    select_dev();
    send_nibble(got, tg);
    repeat (50) @(negedge clk);
    total++; if (busy !== 1'b1) $display("[TB] FAIL timeout_early got busy %b want 1", busy); else passed++;
    repeat (60) @(negedge clk);
    total++; if (busy !== 1'b0) $display("[TB] FAIL timeout_busy got %b want 0", busy); else passed++;
    total++; if (tl !== 1'b1) $display("[TB] FAIL timeout_tl got %b want 1", tl); else passed++;
    total++; if (d !== 4'hF) $display("[TB] FAIL timeout_d got %h want F", d); else passed++;
    send_nibble(got, tg);
    total++;
    if (busy !== 1'b0 || tg != 0)
      $display("[TB] FAIL timeout_no_restart got busy %b toggles %0d want 0/0", busy, tg);
    else passed++;
    deselect_dev();
  endtask

  // A second tr edge during setup is dropped.
  task automatic test_fast_tr();
    logic [3:0] got;
    int         tg, start;
    select_dev();
    start = tlToggles;
    tr = ~tr;
    repeat (2) @(negedge clk);
    tr = ~tr;
    repeat (18) @(negedge clk);
    total++; if (tlToggles - start != 1) $display("[TB] FAIL fast_tl_toggles got %0d want 1", tlToggles - start); else passed++;
    total++; if (lastNib !== 4'h0) $display("[TB] FAIL fast_nib0 got %h want 0", lastNib); else passed++;
    send_nibble(got, tg);
    total++; if (got !== 4'hB) $display("[TB] FAIL fast_next_nib got %h want B", got); else passed++;
    deselect_dev();
  endtask

  // Reset asserted between edges at nibble 6. The block must not restart
  // on its own afterwards.
  task automatic test_reset_mid();
    logic [3:0] got;
    int         tg;
    flags = 4'h3; buttons = 4'h5; x = 8'hA7; y = 8'h1C;
    select_dev();
    for (int i = 0; i < 7; i++) send_nibble(got, tg);
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (tl !== 1'b1) $display("[TB] FAIL rstmid_tl got %b want 1", tl); else passed++;
    total++; if (d !== 4'hF) $display("[TB] FAIL rstmid_d got %h want F", d); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL rstmid_busy got %b want 0", busy); else passed++;
    total++; if (reset_acc !== 1'b0) $display("[TB] FAIL rstmid_acc got %b want 0", reset_acc); else passed++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    send_nibble(got, tg);
    total++; if (busy !== 1'b0) $display("[TB] FAIL rstmid_stays_idle got busy %b want 0", busy); else passed++;
    deselect_dev();
    select_dev();
    send_nibble(got, tg);
    total++; if (got !== 4'h0 || tg != 1) $display("[TB] FAIL rstmid_reselect got %h/%0d want 0/1", got, tg); else passed++;
    deselect_dev();
  endtask

  initial begin
    $display("[TB] saturn_mouse_port bench start");
    test_reset();
    test_full_read();
    test_random();
    test_snapshot();
    test_abort();
    test_timeout();
    test_fast_tr();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired after %0d/%0d checks", passed, total);
    $fatal(1, "[TB] watchdog");
  end

endmodule
